// File: rtl/sseg_pkg.sv
// Shared definitions for the multiplexed seven-segment scan controller.
package sseg_pkg;

  // Active-low pattern with every segment switched off.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRIVE,
    LATCH
  } scan_state_t;

  // Cycles in one full scan: one LOAD cycle plus DRIVE and LATCH for every digit.
  function automatic int frame_len(input int num_digits, input int scan_div);
    return 1 + num_digits * (scan_div + 1);
  endfunction

endpackage

// File: rtl/sseg_lz_mask.sv
// Leading-zero blanking mask. Digit 0 is never blanked, so a zero value still shows one "0".
module sseg_lz_mask #(
  parameter int NUM_DIGITS = 4
) (
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    lz_en,
  output logic [NUM_DIGITS-1:0]   lz_blank
);

  // Walk down from the top digit; a digit blanks while it and everything above it are zero.
  always_comb begin
    logic upper_zero;
    lz_blank   = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero  = upper_zero && (value[4*i +: 4] == 4'h0);
      lz_blank[i] = lz_en && upper_zero;
    end
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Scans one shared hex decoder across NUM_DIGITS displays, latching each digit's
// pattern into its own output register. New values only take effect at frame start.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    value_valid,
  output logic                    value_ready,
  input  logic                    lz_en,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [3:0]              dec_digit,
  input  logic [6:0]              dec_segments,
  output logic [7*NUM_DIGITS-1:0] seg_out,
  output logic                    frame_start
);

  localparam int IDX_W   = (NUM_DIGITS > 1)   ? $clog2(NUM_DIGITS)   : 1;
  localparam int SLOT_W  = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SLOT_W-1:0]  LAST_SLOT  = SLOT_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] LAST_BLINK = BLINK_W'(BLINK_FRAMES - 1);

  scan_state_t             state;
  logic [4*NUM_DIGITS-1:0] active;
  logic [4*NUM_DIGITS-1:0] pend_val;
  logic                    pending;
  logic [IDX_W-1:0]        index;
  logic [IDX_W-1:0]        next_idx;
  logic [SLOT_W-1:0]       slot;
  logic [BLINK_W-1:0]      blink_cnt;
  logic                    blink_phase;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    xfer;
  logic                    blank_cur;
  logic [4*NUM_DIGITS-1:0] load_val;

  assign value_ready = !pending;
  assign xfer        = value_valid && value_ready;
  assign next_idx    = index + 1'b1;
  assign load_val    = xfer ? value : (pending ? pend_val : active);
  assign blank_cur   = blank_mask[index] | lz_blank[index] | (blink_mask[index] & blink_phase);

  sseg_lz_mask #(
    .NUM_DIGITS(NUM_DIGITS)
  ) u_lz_mask (
    .value   (active),
    .lz_en   (lz_en),
    .lz_blank(lz_blank)
  );

  // Scan sequencer with handshake capture, per-digit segment latching and blink timing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      seg_out     <= {NUM_DIGITS{SEG_BLANK}};
      dec_digit   <= 4'h0;
      frame_start <= 1'b0;
      active      <= '0;
      pend_val    <= '0;
      pending     <= 1'b0;
      index       <= '0;
      slot        <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (xfer && (state != LOAD)) begin
        pend_val <= value;
        pending  <= 1'b1;
      end
      case (state)
        IDLE: begin
          state       <= LOAD;
          frame_start <= 1'b1;
        end
        LOAD: begin
          active    <= load_val;
          pending   <= 1'b0;
          index     <= '0;
          slot      <= '0;
          dec_digit <= load_val[3:0];
          state     <= DRIVE;
        end
        DRIVE: begin
          if (slot == LAST_SLOT) begin
            slot  <= '0;
            state <= LATCH;
          end else begin
            slot <= slot + 1'b1;
          end
        end
        LATCH: begin
          seg_out[7*index +: 7] <= blank_cur ? SEG_BLANK : dec_segments;
          if (index == LAST_IDX) begin
            index       <= '0;
            state       <= LOAD;
            frame_start <= 1'b1;
            if (blink_cnt == LAST_BLINK) begin
              blink_cnt   <= '0;
              blink_phase <= !blink_phase;
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
            end
          end else begin
            index     <= next_idx;
            dec_digit <= active[4*next_idx +: 4];
            state     <= DRIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Bench for sseg_scan_ctrl: a 4-digit instance driven by directed phases then random
// traffic, and a 1-digit/1-cycle instance driven randomly, both against a frame-level model.
module tb_sseg_scan_ctrl;
  import sseg_pkg::*;

  localparam int NI = 2;
  localparam int N0 = 4, S0 = 4, B0 = 2;
  localparam int N1 = 1, S1 = 1, B1 = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [15:0] val_s   [NI];
  logic        valid_s [NI];
  logic        lz_s    [NI];
  logic [3:0]  blank_s [NI];
  logic [3:0]  blink_s [NI];

  logic        rdy0, rdy1, fs0, fs1;
  logic [3:0]  dd0, dd1;
  logic [6:0]  ds0, ds1;
  logic [27:0] so0;
  logic [6:0]  so1;

  int  checks = 0;
  int  errors = 0;
  bit  done   = 1'b0;

  // External hex decoder, active-low gfedcba
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  assign ds0 = hex7(dd0);
  assign ds1 = hex7(dd1);

  sseg_scan_ctrl #(.NUM_DIGITS(N0), .SCAN_DIV(S0), .BLINK_FRAMES(B0)) dut0 (
    .clk(clk), .reset(reset), .value(val_s[0]), .value_valid(valid_s[0]),
    .value_ready(rdy0), .lz_en(lz_s[0]), .blank_mask(blank_s[0]), .blink_mask(blink_s[0]),
    .dec_digit(dd0), .dec_segments(ds0), .seg_out(so0), .frame_start(fs0)
  );

  sseg_scan_ctrl #(.NUM_DIGITS(N1), .SCAN_DIV(S1), .BLINK_FRAMES(B1)) dut1 (
    .clk(clk), .reset(reset), .value(val_s[1][3:0]), .value_valid(valid_s[1]),
    .value_ready(rdy1), .lz_en(lz_s[1]), .blank_mask(blank_s[1][0]), .blink_mask(blink_s[1][0]),
    .dec_digit(dd1), .dec_segments(ds1), .seg_out(so1), .frame_start(fs1)
  );

  function automatic int p_n(input int i); return (i == 0) ? N0 : N1; endfunction
  function automatic int p_s(input int i); return (i == 0) ? S0 : S1; endfunction
  function automatic int p_b(input int i); return (i == 0) ? B0 : B1; endfunction

  function automatic logic [27:0] seg_of(input int i);
    return (i == 0) ? so0 : {21'h1FFFFF, so1};
  endfunction
  function automatic logic rdy_of(input int i); return (i == 0) ? rdy0 : rdy1; endfunction
  function automatic logic fs_of(input int i);  return (i == 0) ? fs0 : fs1;   endfunction
  function automatic logic [3:0] dd_of(input int i); return (i == 0) ? dd0 : dd1; endfunction

  task automatic checkOutput(input string name, input int inst, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s inst%0d @%0t: got %h expected %h", name, inst, $time, act, exp);
    end
  endtask

  // Reference model state: current cycle within the run, committed/pending values, expected segments
  int          cyc    [NI];
  int          frames [NI];
  logic [15:0] m_act  [NI];
  logic [15:0] m_pv   [NI];
  bit          m_pend [NI];
  logic [27:0] m_cur  [NI];
  logic [27:0] q0 [$];
  logic [27:0] q1 [$];

  task automatic model_step(input int i);
    int nd, sd, fl, pos, d;
    bit xfer, blank, phase;
    logic [15:0] vmask;
    if (reset) begin
      cyc[i] = 0; frames[i] = 0; m_act[i] = '0; m_pv[i] = '0; m_pend[i] = 1'b0;
      m_cur[i] = 28'hFFFFFFF;
      if (i == 0) begin q0.delete(); q0.push_back(28'hFFFFFFF); end
      else begin q1.delete(); q1.push_back(28'hFFFFFFF); end
      return;
    end
    nd    = p_n(i);
    sd    = p_s(i);
    fl    = frame_len(nd, sd);
    vmask = 16'((32'd1 << (4 * nd)) - 32'd1);
    xfer  = valid_s[i] && !m_pend[i];
    pos   = (cyc[i] == 0) ? -1 : (cyc[i] - 1) % fl;
    if (pos == 0) begin
      if (xfer) m_act[i] = val_s[i] & vmask;
      else if (m_pend[i]) m_act[i] = m_pv[i];
      m_pend[i] = 1'b0;
    end else begin
      if (xfer) begin
        m_pv[i]   = val_s[i] & vmask;
        m_pend[i] = 1'b1;
      end
      if (pos > 0 && pos % (sd + 1) == 0) begin
        d     = pos / (sd + 1) - 1;
        phase = ((frames[i] / p_b(i)) % 2) == 1;
        blank = blank_s[i][d] || (blink_s[i][d] && phase) ||
                (lz_s[i] && d > 0 && (m_act[i] >> (4 * d)) == 16'h0);
        m_cur[i][7*d +: 7] = blank ? 7'h7F : hex7(4'(m_act[i] >> (4 * d)));
        if (d == nd - 1) begin
          frames[i]++;
          if (i == 0) q0.push_back(m_cur[i]); else q1.push_back(m_cur[i]);
        end
      end
    end
    cyc[i]++;
  endtask

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < NI; i++) model_step(i);
  end

  // Monitor: pops a frame expectation on every frame_start and checks per-cycle outputs
  task automatic monitor_step(input int i);
    int sd, fl, pos;
    logic [27:0] e;
    bit have;
    if (reset) begin
      checkOutput("rst_seg_out", i, 32'(seg_of(i)), 32'hFFFFFFF);
      checkOutput("rst_value_ready", i, 32'(rdy_of(i)), 32'd1);
      checkOutput("rst_dec_digit", i, 32'(dd_of(i)), 32'd0);
      checkOutput("rst_frame_start", i, 32'(fs_of(i)), 32'd0);
      return;
    end
    sd  = p_s(i);
    fl  = frame_len(p_n(i), sd);
    pos = (cyc[i] == 0) ? -1 : (cyc[i] - 1) % fl;
    checkOutput("frame_start", i, 32'(fs_of(i)), 32'(pos == 0));
    checkOutput("value_ready", i, 32'(rdy_of(i)), 32'(!m_pend[i]));
    checkOutput("seg_out", i, 32'(seg_of(i)), 32'(m_cur[i]));
    if (pos > 0 && pos % (sd + 1) != 0)
      checkOutput("dec_digit", i, 32'(dd_of(i)),
                  32'(4'(m_act[i] >> (4 * ((pos - 1) / (sd + 1))))));
    if (fs_of(i)) begin
      have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (!have) checkOutput("scoreboard_empty", i, 32'd1, 32'd0);
      else begin
        e = (i == 0) ? q0.pop_front() : q1.pop_front();
        checkOutput("frame_seg", i, 32'(seg_of(i)), 32'(e));
      end
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) monitor_step(i);
  end

  // Offer a value and hold it until taken; called #1 after a rising edge
  task automatic applyStimulus(input int i, input logic [15:0] v, input int budget);
    bit got;
    got        = 1'b0;
    val_s[i]   = v;
    valid_s[i] = 1'b1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!reset && rdy_of(i)) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    valid_s[i] = 1'b0;
    if (!got) checkOutput("handshake_timeout", i, 32'd0, 32'd1);
  endtask

  task automatic waitFrames(input int i, input int n);
    int budget;
    bit seen;
    budget = 3 * frame_len(p_n(i), p_s(i));
    for (int f = 0; f < n; f++) begin
      seen = 1'b0;
      for (int k = 0; k < budget; k++) begin
        @(negedge clk);
        if (fs_of(i)) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) checkOutput("frame_timeout", i, 32'd0, 32'd1);
    end
  endtask

  // Random traffic for the single-digit instance
  initial begin
    @(negedge reset);
    while (!done) begin
      @(posedge clk);
      #1;
      if (!reset) begin
        if ($urandom_range(0, 3) == 0) begin
          lz_s[1]    = 1'($urandom_range(0, 1));
          blank_s[1] = 4'($urandom_range(0, 7) == 0);
          blink_s[1] = 4'($urandom_range(0, 1));
        end
        if ($urandom_range(0, 2) == 0) applyStimulus(1, 16'($urandom), 20);
      end
    end
  end

  // Directed phases then random traffic on the 4-digit instance
  initial begin
    reset = 1'b1;
    for (int i = 0; i < NI; i++) begin
      val_s[i] = '0; valid_s[i] = 1'b0; lz_s[i] = 1'b0; blank_s[i] = '0; blink_s[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(0, 16'h1234, 60);
    waitFrames(0, 3);

    @(posedge clk); #1;
    lz_s[0] = 1'b1;
    applyStimulus(0, 16'h0050, 60);
    waitFrames(0, 3);
    @(posedge clk); #1;
    applyStimulus(0, 16'h0000, 60);
    waitFrames(0, 3);

    @(posedge clk); #1;
    lz_s[0] = 1'b0;
    waitFrames(0, 1);
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(0, 16'hABCD, 60);
    applyStimulus(0, 16'h5A5A, 60);
    waitFrames(0, 4);

    @(posedge clk); #1;
    blink_s[0] = 4'b0001;
    blank_s[0] = 4'b1000;
    applyStimulus(0, 16'h1234, 60);
    waitFrames(0, 8);
    @(posedge clk); #1;
    blink_s[0] = '0;
    blank_s[0] = '0;

    waitFrames(0, 1);
    repeat (12) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    waitFrames(0, 2);

    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 2) == 0) begin
        lz_s[0]    = 1'($urandom_range(0, 1));
        blank_s[0] = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
        blink_s[0] = 4'($urandom_range(0, 15));
      end
      applyStimulus(0, 16'($urandom) & {4'($urandom_range(0, 15)), 12'hFFF}, 60);
      repeat ($urandom_range(0, 30)) @(posedge clk);
      #1;
    end
    waitFrames(0, 3);

    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
- Sequences one shared hex-to-seven-segment decoder across NUM_DIGITS displays.
- Presents one nibble at a time to the decoder, captures the decoder's active-low pattern and holds it in a per-digit output register.
- Adds leading-zero blanking, per-digit forced blank and per-digit blink.
- Accepts new display values through a valid/ready handshake; values commit only at frame boundaries, so a frame never mixes old and new digits.

Parameters:
- NUM_DIGITS, 4, number of displays and nibbles (range 1..8).
- SCAN_DIV, 1000, cycles the decoder is driven per digit before capture (>=1).
- BLINK_FRAMES, 256, frames per blink half-period (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-high.
- value  in  4*NUM_DIGITS  hex value to display; nibble i goes to digit i, digit 0 is least significant.
- value_valid  in  1  value is offered.
- value_ready  out  1  block can accept value.
- lz_en  in  1  enable leading-zero blanking.
- blank_mask  in  NUM_DIGITS  per-digit forced blank.
- blink_mask  in  NUM_DIGITS  per-digit blink enable.
- dec_digit  out  4  nibble driven to the shared decoder.
- dec_segments  in  7  active-low pattern returned combinationally by the decoder.
- seg_out  out  7*NUM_DIGITS  registered active-low segments; bits [7i+6:7i] belong to digit i.
- frame_start  out  1  one-cycle pulse in each LOAD cycle.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. All state is reset asynchronously.
- Reset values:
  - state=IDLE, seg_out all 7'h7F (every segment off).
  - value_ready=1, dec_digit=0, frame_start=0.
  - active value, pending value and pending flag=0.
  - digit index=0, slot counter=0, blink counter=0, blink phase=0.
- FSM states: IDLE, LOAD, DRIVE, LATCH.
  - IDLE -> LOAD unconditionally after one cycle.
  - LOAD (1 cycle):
    - frame_start=1, index=0.
    - Active value takes one of three sources, in this priority: the value accepted this cycle; else pending if set; else unchanged.
    - Pending flag clears.
    - Goes to DRIVE.
  - DRIVE (SCAN_DIV cycles):
    - dec_digit = active nibble[index], held stable for the whole state.
    - Slot counter counts 0..SCAN_DIV-1, then goes to LATCH.
  - LATCH (1 cycle):
    - seg_out[index] <= blank_i ? 7'h7F : dec_segments, visible the next cycle.
    - If index==NUM_DIGITS-1: go to LOAD and advance the blink counter. Otherwise index+1, go to DRIVE.
- Frame length = 1 + NUM_DIGITS*(SCAN_DIV+1) cycles.
- blank_i = blank_mask[i] OR lz_blank[i] OR (blink_mask[i] AND blink_phase).
  - lz_blank[i]=1 when lz_en is set, nibble i==0, and every nibble above i is 0.
  - lz_blank[0] is always 0, so value 0 shows a single "0".
  - lz_blank is computed from the active value.
  - The masks are sampled in the LATCH cycle.
- Blink: the counter counts frames 0..BLINK_FRAMES-1. When it wraps, blink_phase toggles.
- Handshake:
  - A transfer occurs when value_valid && value_ready.
  - value_ready = !pending.
  - A transfer outside LOAD stores into pending and sets the pending flag. value_ready drops the following cycle.
  - A transfer in a LOAD cycle bypasses pending straight to active. The pending flag stays 0.
  - value_ready returns high the cycle after LOAD.
  - value_valid while ready=0 is ignored; the source holds.
- Width rules: dec_digit is 4 bits. Slot counter is $clog2(SCAN_DIV) bits, minimum 1. Index is $clog2(NUM_DIGITS) bits, minimum 1.
- Reset mid-frame: outputs return to reset values immediately. Any pending value is discarded.
- seg_out changes only in the cycle after LATCH, or on reset.

Decomposition:
- sseg_pkg holds:
  - SEG_BLANK = 7'h7F.
  - scan_state_t enum {IDLE, LOAD, DRIVE, LATCH}.
  - A function returning the frame length from NUM_DIGITS and SCAN_DIV, for benches.
- One sub-module: sseg_lz_mask, combinational. Inputs: the active value and lz_en. Output: the NUM_DIGITS-bit lz_blank vector.
- The decoder is instantiated alongside this block at the top level, wired through dec_digit and dec_segments.

Test Plan:
- Basic display, leading-zero blanking off: NUM_DIGITS=4, SCAN_DIV=4, reset released, value=16'h1234 with valid at cycle 1 (accepted in the LOAD cycle).
  - Digit 0 captured at cycle 6 and visible at cycle 7 as the decoder pattern for 4.
  - After the first frame, seg_out = {pattern(1), pattern(2), pattern(3), pattern(4)}.
  - frame_start pulses at cycles 1 and 22.
- Leading-zero blanking: lz_en=1, value=16'h0050.
  - Digits 3 and 2 = 7'h7F, digit 1 shows 5, digit 0 shows 0.
  - value=16'h0000 shows only digit 0 as 0.
- Mid-frame update: offer 16'hABCD during DRIVE of frame N.
  - value_ready drops the next cycle.
  - Frame N digits stay old; frame N+1 shows ABCD.
  - value_ready rises the cycle after frame N+1's LOAD.
  - A second offer while ready=0 is not taken.
- Blink and force blank: BLINK_FRAMES=2, blink_mask=4'b0001, blank_mask=4'b1000.
  - Digit 3 is always 7'h7F.
  - Digit 0 alternates value/blank every 2 frames.
- Asynchronous reset: assert reset in the DRIVE state of digit 2.
  - Same cycle: seg_out all 7'h7F, value_ready=1, dec_digit=0.
  - After release, the scan restarts with IDLE then LOAD.
- Edge configuration: NUM_DIGITS=1, SCAN_DIV=1.
  - Frame = 3 cycles; frame_start pulses every 3 cycles.
  - seg_out updates every 3rd cycle.
